// File: rtl/ifu_prefetch_pkg.sv
// Shared constants for the instruction fetch unit.
package ifu_prefetch_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned INST_WIDTH = 32;

  localparam logic [XLEN_DEF-1:0]   DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INST_WIDTH-1:0] NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch queue: DEPTH x W synchronous FIFO with flush; head is read combinationally.
module ifu_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: fetch PC, credit-limited ROM issue, prefetch queue, redirect.
// Optional macro IFU_BYPASS_EN forwards a response straight to decode when the queue is empty.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned         XLEN     = XLEN_DEF,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [XLEN-1:0]     RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] rom_addr,
  output logic            rom_req,
  input  logic [XLEN-1:0] rom_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   issued_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] head;
  logic [OW-1:0]     occupancy;
  logic              redirect;
  logic              resp_ok;
  logic              push;
  logic              pop;

  assign redirect  = redirect_valid && !rst;
  assign resp_ok   = inflight && !redirect && !rst;
  assign occupancy = OW'(count) + OW'(inflight);

  // Issue whenever queued plus in-flight entries leave room, or unconditionally on redirect.
  always_comb begin
    rom_req  = 1'b0;
    rom_addr = fetch_pc;
    if (!rst) begin
      if (redirect) begin
        rom_req  = 1'b1;
        rom_addr = {redirect_pc[XLEN-1:2], 2'b00};
      end else begin
        rom_req  = occupancy < OW'(DEPTH);
      end
    end
  end

`ifdef IFU_BYPASS_EN
  logic bypass;

  // An empty queue lets the arriving response go straight to decode; it is queued only if refused.
  always_comb begin
    bypass     = resp_ok && (count == '0);
    inst_valid = bypass || (!rst && !redirect_valid && (count != '0));
    inst       = bypass ? rom_data  : head[2*XLEN-1:XLEN];
    inst_pc    = bypass ? issued_pc : head[XLEN-1:0];
    push       = resp_ok && !(bypass && inst_ready);
    pop        = inst_valid && inst_ready && !bypass;
  end
`else
  always_comb begin
    inst_valid = !rst && !redirect_valid && (count != '0);
    inst       = head[2*XLEN-1:XLEN];
    inst_pc    = head[XLEN-1:0];
    push       = resp_ok;
    pop        = inst_valid && inst_ready;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight  <= 1'b0;
    end else begin
      inflight <= rom_req;
      if (rom_req) begin
        fetch_pc  <= rom_addr + XLEN'(4);
        issued_pc <= rom_addr;
      end
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({rom_data, issued_pc}),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a ROM model and an expected-PC scoreboard.
module tb_ifu_prefetch;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
`ifdef IFU_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] rom_addr;
  logic            rom_req;
  logic [XLEN-1:0] rom_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  int              compared   = 0;
  int              mismatched = 0;
  int              xfers      = 0;
  logic [XLEN-1:0] exp_q[$];

  always #5 clk = ~clk;

  ifu_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_req        (rom_req),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  // ROM with 1-cycle latency; word i holds i.
  always @(posedge clk) begin
    rom_data <= rom_req ? (rom_addr >> 2) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_seq(input logic [XLEN-1:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + XLEN'(4 * i));
  endtask

  // Every transfer must match the head of the expected stream.
  always @(negedge clk) begin
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      logic [XLEN-1:0] e;
      xfers++;
      compared++;
      assert (exp_q.size() != 0)
      else begin
        mismatched++;
        $error("FAIL unexpected_xfer: observed pc %h expected no transfer", inst_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("xfer_pc", inst_pc, e);
        chk("xfer_inst", inst, e >> 2);
      end
    end
  end

  initial begin
    int x0;
    int issues;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_rom_req", rom_req, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_rom_addr", rom_addr, 32'h0);

    // Release, first request and issue-to-valid latency
    push_seq(32'h0, 40);
    rst = 1'b0;
    #1;
    chk("first_req", rom_req, 1'b1);
    chk("first_addr", rom_addr, 32'h0);
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk("latency_valid", inst_valid, (k >= LAT) ? 1'b1 : 1'b0);
    end
    x0 = xfers;
    repeat (12) tick();
    chk("throughput", 32'(xfers - x0), 32'd12);

    // Stall from reset: four issues, head held at PC 0, then drain in order
    rst        = 1'b1;
    inst_ready = 1'b0;
    tick();
    exp_q.delete();
    push_seq(32'h0, 40);
    rst    = 1'b0;
    issues = 0;
    repeat (10) begin
      #1;
      if (rom_req) issues++;
      tick();
    end
    chk("stall_issues", 32'(issues), 32'd4);
    chk("stall_req", rom_req, 1'b0);
    chk("stall_valid", inst_valid, 1'b1);
    chk("stall_pc", inst_pc, 32'h0);
    chk("stall_inst", inst, 32'h0);
    inst_ready = 1'b1;
    x0 = xfers;
    repeat (8) tick();
    chk("drain_count", 32'(xfers - x0), 32'd8);

    // Redirect with three queued entries and one in flight
    rst        = 1'b1;
    inst_ready = 1'b0;
    tick();
    exp_q.delete();
    rst = 1'b0;
    repeat (4) tick();
    chk("pre_redir_valid", inst_valid, 1'b1);
    chk("pre_redir_req", rom_req, 1'b0);
    push_seq(32'h100, 40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("redir_valid", inst_valid, 1'b0);
    chk("redir_req", rom_req, 1'b1);
    chk("redir_addr", rom_addr, 32'h100);
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    tick();
    chk("redir_first_valid", inst_valid, 1'b1);
    chk("redir_first_pc", inst_pc, 32'h100);
    repeat (6) tick();

    // Misaligned redirect target is word-aligned
    exp_q.delete();
    push_seq(32'h200, 40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    chk("align_addr", rom_addr, 32'h200);
    tick();
    redirect_valid = 1'b0;
    repeat (6) tick();

    // Back-to-back redirects: only the second target is delivered
    exp_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    push_seq(32'h80, 40);
    redirect_pc = 32'h80;
    #1;
    chk("b2b_addr", rom_addr, 32'h80);
    tick();
    redirect_valid = 1'b0;
    x0 = xfers;
    repeat (8) tick();
    chk("b2b_progress", (xfers - x0 >= 6) ? 1'b1 : 1'b0, 1'b1);

    // Fetch PC wraps at the top of the address space
    exp_q.delete();
    push_seq(32'hFFFF_FFFC, 40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    x0 = xfers;
    repeat (6) tick();
    chk("wrap_progress", (xfers - x0 >= 4) ? 1'b1 : 1'b0, 1'b1);

    // Reset over a full queue with a concurrent redirect
    inst_ready = 1'b0;
    repeat (8) tick();
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1;
    chk("rstq_req_now", rom_req, 1'b0);
    chk("rstq_valid_now", inst_valid, 1'b0);
    tick();
    chk("rstq_valid", inst_valid, 1'b0);
    chk("rstq_req", rom_req, 1'b0);
    exp_q.delete();
    push_seq(32'h0, 40);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    #1;
    chk("restart_req", rom_req, 1'b1);
    chk("restart_addr", rom_addr, 32'h0);
    tick();
    tick();
    chk("restart_valid", inst_valid, 1'b1);
    chk("restart_pc", inst_pc, 32'h0);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
